// File: rtl/pc_seq_pkg.sv
// Shared types and default constants for the next-PC sequencer.
//  seq_state_e   : boot / run / fault sequencer states
//  DefResetVec   : default boot address
//  DefIrqVec     : default interrupt handler entry
package pc_seq_pkg;

   typedef enum logic [1:0] {StBoot, StRun, StFault} seq_state_e;

   localparam logic [7:0] DefResetVec = 8'h00;
   localparam logic [7:0] DefIrqVec   = 8'hF0;

endpackage

// File: rtl/pc_ret_stack.sv
// Hardware return-address LIFO.
//  clk, rst_n : clock, async active-low reset (clears the pointer only)
//  push, pop  : push push_data / drop top entry (ignored when full / empty)
//  push_data  : address to push
//  top        : most recently pushed entry (undefined when empty)
//  full, empty: occupancy flags
module pc_ret_stack #(
   parameter int unsigned AW    = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic [AW-1:0] push_data,
   output logic [AW-1:0] top,
   output logic          full,
   output logic          empty
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned SW = $clog2(DEPTH + 1);

   logic [SW-1:0] sp;
   logic [AW-1:0] mem [DEPTH];
   logic [PW-1:0] top_idx;

   assign full    = (sp == SW'(DEPTH));
   assign empty   = (sp == '0);
   assign top_idx = PW'(sp - SW'(1));
   assign top     = mem[top_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp <= '0;
      end else if (push && !full) begin
         sp <= sp + SW'(1);
      end else if (pop && !empty) begin
         sp <= sp - SW'(1);
      end
   end

   // Contents need no reset: an entry is only read after it was written.
   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[sp[PW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: resolves stall / iret / ret / call / branch / interrupt requests into
// the PC's jump, hold and jump_line controls; owns the return stack, the interrupt-pending
// latch and the boot/run/fault FSM.
//  clk, rst_n        : clock, async active-low reset
//  pc_now            : current PC value
//  stall_req         : hold the PC, ignore everything else this cycle
//  branch_req/target : taken branch
//  call_req/target   : call, pushes pc_now+1
//  ret_req, iret_req : return (iret also leaves the handler)
//  irq               : level interrupt request
//  jump, hold        : PC controls (combinational, same-edge effect)
//  jump_line         : PC load value
//  flush             : discard instruction at pc_now
//  irq_ack           : registered one-cycle pulse after an interrupt is taken
//  in_isr            : handler active, interrupts masked
//  fault             : sticky stack overflow/underflow
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int unsigned    AW        = 8,
   parameter int unsigned    DEPTH     = 4,
   parameter logic [AW-1:0]  RESET_VEC = AW'(DefResetVec),
   parameter logic [AW-1:0]  IRQ_VEC   = AW'(DefIrqVec)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] pc_now,
   input  logic          stall_req,
   input  logic          branch_req,
   input  logic [AW-1:0] branch_target,
   input  logic          call_req,
   input  logic [AW-1:0] call_target,
   input  logic          ret_req,
   input  logic          iret_req,
   input  logic          irq,
   output logic          jump,
   output logic          hold,
   output logic [AW-1:0] jump_line,
   output logic          flush,
   output logic          irq_ack,
   output logic          in_isr,
   output logic          fault
);

   seq_state_e    state;
   logic          pending;
   logic          push, pop;
   logic [AW-1:0] push_data;
   logic [AW-1:0] top;
   logic          full, empty;
   logic          take_irq;
   logic          do_iret;
   logic          stack_err;

   pc_ret_stack #(
      .AW    (AW),
      .DEPTH (DEPTH)
   ) u_stack (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .pop       (pop),
      .push_data (push_data),
      .top       (top),
      .full      (full),
      .empty     (empty)
   );

   // Priority mux. A stack error replaces the request's effect with a hold.
   always_comb begin
      jump      = 1'b0;
      hold      = 1'b0;
      jump_line = '0;
      flush     = 1'b0;
      push      = 1'b0;
      pop       = 1'b0;
      push_data = pc_now + AW'(1);
      take_irq  = 1'b0;
      do_iret   = 1'b0;
      stack_err = 1'b0;
      unique case (state)
         StBoot: begin
            jump      = 1'b1;
            jump_line = RESET_VEC;
            flush     = 1'b1;
         end
         StFault: begin
            hold  = 1'b1;
            flush = 1'b1;
         end
         default: begin
            if (stall_req) begin
               hold = 1'b1;
            end else if (iret_req || ret_req) begin
               if (empty) begin
                  stack_err = 1'b1;
               end else begin
                  pop       = 1'b1;
                  jump      = 1'b1;
                  jump_line = top;
                  do_iret   = iret_req;
               end
            end else if (call_req) begin
               if (full) begin
                  stack_err = 1'b1;
               end else begin
                  push      = 1'b1;
                  jump      = 1'b1;
                  jump_line = call_target;
               end
            end else if (branch_req) begin
               jump      = 1'b1;
               jump_line = branch_target;
            end else if (pending && !in_isr) begin
               if (full) begin
                  stack_err = 1'b1;
               end else begin
                  push      = 1'b1;
                  push_data = pc_now;
                  jump      = 1'b1;
                  jump_line = IRQ_VEC;
                  flush     = 1'b1;
                  take_irq  = 1'b1;
               end
            end
            if (stack_err) begin
               hold = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= StBoot;
         pending <= 1'b0;
         in_isr  <= 1'b0;
         fault   <= 1'b0;
         irq_ack <= 1'b0;
      end else begin
         irq_ack <= take_irq;
         unique case (state)
            StBoot: state <= StRun;
            StRun: begin
               if (stack_err) begin
                  state <= StFault;
                  fault <= 1'b1;
               end
               if (take_irq) begin
                  pending <= 1'b0;
                  in_isr  <= 1'b1;
               end else begin
                  if (irq && !in_isr) begin
                     pending <= 1'b1;
                  end
                  if (do_iret) begin
                     in_isr <= 1'b0;
                  end
               end
            end
            default: state <= StFault;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a driver issues one request set per cycle and pushes the
// expected controls from a queue-based reference model; a monitor pops and compares. A real PC
// register closes the loop so pc_now follows the DUT's controls.
module tb_pc_sequencer;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] pc_now;
   logic       stall_req, branch_req, call_req, ret_req, iret_req, irq;
   logic [7:0] branch_target, call_target;
   logic       jump, hold, flush, irq_ack, in_isr, fault;
   logic [7:0] jump_line;

   int checks = 0;
   int failures = 0;

   typedef struct {
      bit         j, h, f, ack, isr, flt;
      logic [7:0] jl, pc;
   } exp_t;

   exp_t sb[$];

   // Reference model state
   bit         m_boot, m_fault, m_pend, m_isr, m_ack;
   logic [7:0] m_pc;
   logic [7:0] m_stk[$];

   pc_sequencer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .pc_now        (pc_now),
      .stall_req     (stall_req),
      .branch_req    (branch_req),
      .branch_target (branch_target),
      .call_req      (call_req),
      .call_target   (call_target),
      .ret_req       (ret_req),
      .iret_req      (iret_req),
      .irq           (irq),
      .jump          (jump),
      .hold          (hold),
      .jump_line     (jump_line),
      .flush         (flush),
      .irq_ack       (irq_ack),
      .in_isr        (in_isr),
      .fault         (fault)
   );

   always #5 clk = ~clk;

   // The PC register the sequencer drives.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_now <= 8'h00;
      else if (!hold) pc_now <= jump ? jump_line : pc_now + 8'h01;
   end

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, exp);
      end
   endtask

   // Monitor: controls are valid every cycle once inputs settle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pc", pc_now, e.pc);
            chk("jump", jump, e.j);
            chk("hold", hold, e.h);
            chk("flush", flush, e.f);
            if (e.j) chk("jump_line", jump_line, e.jl);
            chk("irq_ack", irq_ack, e.ack);
            chk("in_isr", in_isr, e.isr);
            chk("fault", fault, e.flt);
         end
      end
   end

   task automatic model_reset();
      m_boot = 1; m_fault = 0; m_pend = 0; m_isr = 0; m_ack = 0;
      m_pc = 8'h00;
      m_stk.delete();
   endtask

   // Called at a negedge; returns at the next negedge.
   task automatic step(input bit s, input bit b, input logic [7:0] bt, input bit c,
                       input logic [7:0] ct, input bit r, input bit ir, input bit q);
      exp_t e;
      bit n_boot, n_fault, n_pend, n_isr, took, bad;
      logic [7:0] n_stk[$];
      stall_req = s; branch_req = b; branch_target = bt; call_req = c; call_target = ct;
      ret_req = r; iret_req = ir; irq = q;
      e.j = 0; e.h = 0; e.f = 0; e.jl = 8'h00;
      e.ack = m_ack; e.isr = m_isr; e.flt = m_fault; e.pc = m_pc;
      n_boot = 0; n_fault = m_fault; n_pend = m_pend; n_isr = m_isr; took = 0; bad = 0;
      n_stk = m_stk;
      if (m_boot) begin
         e.j = 1; e.jl = 8'h00; e.f = 1;
      end else if (m_fault) begin
         e.h = 1; e.f = 1;
      end else begin
         if (q && !m_isr) n_pend = 1;
         if (s) e.h = 1;
         else if (ir || r) begin
            if (n_stk.size() == 0) bad = 1;
            else begin
               e.j = 1; e.jl = n_stk.pop_back();
               if (ir) n_isr = 0;
            end
         end else if (c) begin
            if (n_stk.size() == DEPTH) bad = 1;
            else begin
               n_stk.push_back(m_pc + 8'h01); e.j = 1; e.jl = ct;
            end
         end else if (b) begin
            e.j = 1; e.jl = bt;
         end else if (m_pend && !m_isr) begin
            if (n_stk.size() == DEPTH) bad = 1;
            else begin
               n_stk.push_back(m_pc); e.j = 1; e.jl = 8'hF0; e.f = 1;
               took = 1; n_isr = 1; n_pend = 0;
            end
         end
         if (bad) begin
            e.h = 1; n_fault = 1;
         end
      end
      sb.push_back(e);
      @(posedge clk);
      if (!e.h) m_pc = e.j ? e.jl : m_pc + 8'h01;
      m_boot = n_boot; m_fault = n_fault; m_pend = n_pend; m_isr = n_isr; m_ack = took;
      m_stk = n_stk;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, 8'h00, 0, 0, 0);
   endtask

   // Called at a negedge; checks asynchronous reset values, releases at the next negedge.
   task automatic do_reset();
      rst_n = 0;
      stall_req = 0; branch_req = 0; call_req = 0; ret_req = 0; iret_req = 0; irq = 0;
      branch_target = 8'h00; call_target = 8'h00;
      #1;
      chk("rst_jump", jump, 1);
      chk("rst_hold", hold, 0);
      chk("rst_jump_line", jump_line, 8'h00);
      chk("rst_flush", flush, 1);
      chk("rst_irq_ack", irq_ack, 0);
      chk("rst_in_isr", in_isr, 0);
      chk("rst_fault", fault, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1;
   endtask

   initial begin
      @(negedge clk);
      // Boot then count
      do_reset();
      idle(4);
      // Call / return
      step(0, 1, 8'h10, 0, 8'h00, 0, 0, 0);
      step(0, 0, 8'h00, 1, 8'h40, 0, 0, 0);
      idle(2);
      step(0, 0, 8'h00, 0, 8'h00, 1, 0, 0);
      idle(1);
      // Nested calls to overflow, then frozen
      for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 8'h00, 1, 8'(8'h50 + i), 0, 0, 0);
      idle(3);
      // Underflow
      do_reset();
      idle(1);
      step(0, 0, 8'h00, 0, 8'h00, 1, 0, 0);
      idle(2);
      // Irq during stall, masked second irq, iret
      do_reset();
      idle(1);
      step(0, 1, 8'h20, 0, 8'h00, 0, 0, 0);
      step(1, 0, 8'h00, 0, 8'h00, 0, 0, 1);
      step(1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
      step(1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
      idle(2);
      step(0, 0, 8'h00, 0, 8'h00, 0, 0, 1);
      idle(2);
      step(0, 0, 8'h00, 0, 8'h00, 0, 1, 0);
      idle(2);
      // Branch beats irq in the same cycle
      do_reset();
      idle(1);
      step(0, 1, 8'h08, 0, 8'h00, 0, 0, 0);
      step(0, 1, 8'h30, 0, 8'h00, 0, 0, 1);
      idle(3);
      // Return address wraps at FF
      do_reset();
      idle(1);
      step(0, 1, 8'hFF, 0, 8'h00, 0, 0, 0);
      step(0, 0, 8'h00, 1, 8'h40, 0, 0, 0);
      step(0, 0, 8'h00, 0, 8'h00, 1, 0, 0);
      idle(2);
      // Randomized segments, each starting from reset (also covers reset mid-operation)
      for (int seg = 0; seg < 40; seg++) begin
         do_reset();
         for (int i = 0; i < 50; i++) begin
            step($urandom_range(0, 99) < 10, $urandom_range(0, 99) < 15, 8'($urandom),
                 $urandom_range(0, 99) < 18, 8'($urandom), $urandom_range(0, 99) < 8,
                 $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 20);
         end
      end
      @(negedge clk);
      #3;
      chk("scoreboard_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
